// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial initiator for a combinational 1-bit ALU slice.
// Operands are streamed LSB first, one bit per clock. The slice carry/borrow
// output is fed back into its carry input, and the WIDTH-bit result is
// assembled from the slice result bits.
// Optional feature: define SERIAL_ALU_OVF_EN to add overflow_o
// (two's-complement overflow on ADD).
//
// Handshake: start_i is sampled only in IDLE or DONE. An accepted start makes
// busy_o go high for exactly WIDTH cycles, followed by a one-cycle done_o
// pulse. start_i during RUN is ignored and is not queued.
// state_o exposes the FSM state (IDLE=0, RUN=1, DONE=2) for debug.
module serial_alu_seq #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  output logic [1:0]       aluctr_o,
  input  logic             d_i,
  input  logic             e_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
`ifdef SERIAL_ALU_OVF_EN
  output logic             overflow_o,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0]    OP_ADD = 2'b00;
  localparam logic [1:0]    OP_CMP = 2'b10;
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;     // result bits collected so far, MSB-aligned
  logic [WIDTH-1:0] res_next;   // result shift register after this edge
  logic             carry_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_out_q;
  logic             is_arith;
  logic             accept;
  logic             last_bit;

  assign is_arith = (op_q == OP_ADD) || (op_q == OP_CMP);
  assign accept   = start_i && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == RUN) && (cnt == LAST);
  assign res_next = {d_i, res_sh};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: IDLE/DONE accept a start, RUN ends after the last bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start_i ? RUN : IDLE;
      RUN:     state_nxt = (cnt == LAST) ? DONE : RUN;
      DONE:    state_nxt = start_i ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, shift one bit per RUN cycle,
  // publish the result and flags at the final RUN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      carry_q     <= 1'b0;
      op_q        <= 2'b00;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      a_sh    <= opa_i;
      b_sh    <= opb_i;
      res_sh  <= '0;
      carry_q <= 1'b0;
      op_q    <= op_i;
    end else if (state == RUN) begin
      cnt     <= cnt + CW'(1);
      a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
      res_sh  <= res_next[WIDTH-1:1];
      carry_q <= e_i;
      if (last_bit) begin
        // CMP only produces a flag; its result word is defined as zero.
        result_q    <= (op_q == OP_CMP) ? '0 : res_next;
        carry_out_q <= is_arith ? e_i : 1'b0;
      end
    end
  end

`ifdef SERIAL_ALU_OVF_EN
  logic ovf_q;

  // Overflow: carry into the MSB (current carry_q) differs from carry out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ovf_q <= 1'b0;
    else if (last_bit) ovf_q <= (op_q == OP_ADD) ? (carry_q ^ e_i) : 1'b0;
  end

  assign overflow_o = ovf_q;
`endif

  assign a_o      = (state == RUN) ? a_sh[0] : 1'b0;
  assign b_o      = (state == RUN) ? b_sh[0] : 1'b0;
  assign c_o      = (state == RUN) && is_arith ? carry_q : 1'b0;
  assign aluctr_o = op_q;
  assign result_o = result_q;
  assign carry_o  = carry_out_q;
  assign busy_o   = (state == RUN);
  assign done_o   = (state == DONE);
  assign state_o  = state;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed testbench for serial_alu_seq with a behavioural 1-bit ALU slice.
module tb_serial_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] opa_i, opb_i;
  logic         a_o, b_o, c_o;
  logic [1:0]   aluctr_o;
  logic         d_i, e_i;
  logic [W-1:0] result_o;
  logic         carry_o;
  logic         busy_o, done_o;
  logic [1:0]   state_o;
`ifdef SERIAL_ALU_OVF_EN
  logic         overflow_o;
`endif

  int tests  = 0;
  int failed = 0;
  int done_cnt = 0;

  serial_alu_seq #(.WIDTH(W), .CW(4)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .opa_i(opa_i), .opb_i(opb_i),
    .a_o(a_o), .b_o(b_o), .c_o(c_o), .aluctr_o(aluctr_o),
    .d_i(d_i), .e_i(e_i),
    .result_o(result_o), .carry_o(carry_o),
`ifdef SERIAL_ALU_OVF_EN
    .overflow_o(overflow_o),
`endif
    .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Behavioural slice: combinational, same cycle.
  always_comb begin
    d_i = 1'b0;
    e_i = 1'b0;
    case (aluctr_o)
      2'b00: begin
        d_i = a_o ^ b_o ^ c_o;
        e_i = (a_o & b_o) | (a_o & c_o) | (b_o & c_o);
      end
      2'b01: d_i = a_o & b_o;
      2'b10: e_i = (a_o & ~b_o) | (~(a_o ^ b_o) & c_o);
      default: d_i = a_o ^ b_o;
    endcase
  end

  // Count done pulses away from the active edge.
  always @(negedge clk) if (done_o) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one operation from the current (off-edge) time and follow it to
  // its DONE cycle. Returns at #1 after the edge that enters DONE, with
  // start_i released. hold keeps start_i high through RUN.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_res, input logic exp_c,
                        input logic exp_ovf, input bit hold);
    logic [W-1:0] res_before;
    logic         c_before;
    res_before = result_o;
    c_before   = carry_o;
    start_i = 1'b1;
    op_i    = op;
    opa_i   = a;
    opb_i   = b;
    @(posedge clk); #1;
    if (!hold) begin
      start_i = 1'b0;
      opa_i   = $urandom_range(0, 255);
      opb_i   = $urandom_range(0, 255);
    end
    for (int n = 0; n < W; n++) begin
      check({tag, " busy"}, busy_o, 1'b1);
      check({tag, " a_bit"}, a_o, a[n]);
      check({tag, " b_bit"}, b_o, b[n]);
      if (n == 0 || n == W-1) begin
        check({tag, " done_low"}, done_o, 1'b0);
        check({tag, " aluctr"}, aluctr_o, op);
        check({tag, " res_held"}, result_o, res_before);
        check({tag, " c_held"}, carry_o, c_before);
      end
      @(posedge clk); #1;
    end
    check({tag, " done"}, done_o, 1'b1);
    check({tag, " busy_off"}, busy_o, 1'b0);
    check({tag, " result"}, result_o, exp_res);
    check({tag, " carry"}, carry_o, exp_c);
    check({tag, " a_idle"}, a_o, 1'b0);
`ifdef SERIAL_ALU_OVF_EN
    check({tag, " ovf"}, overflow_o, exp_ovf);
`else
    if (exp_ovf === 1'bx) $display("unused");
`endif
    start_i = 1'b0;
  endtask

  // One idle edge after DONE: pulse must end, outputs stay stable.
  task automatic idle_after(input string tag, input logic [W-1:0] exp_res,
                            input logic exp_c);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, done_o, 1'b0);
    check({tag, " idle_state"}, state_o, 2'd0);
    check({tag, " res_stable"}, result_o, exp_res);
    check({tag, " c_stable"}, carry_o, exp_c);
    check({tag, " aluctr_hold"}, aluctr_o, dut.aluctr_o);
  endtask

  initial begin
    int done_before;
    rst = 1'b1; start_i = 1'b0; op_i = 2'b00; opa_i = '0; opb_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst state", state_o, 2'd0);
    check("rst busy", busy_o, 1'b0);
    check("rst done", done_o, 1'b0);
    check("rst result", result_o, 8'h00);
    check("rst carry", carry_o, 1'b0);
    check("rst aluctr", aluctr_o, 2'b00);
    @(negedge clk); rst = 1'b0;

    // AND first so the result register is nonzero before the reset test.
    run_op("and", 2'b01, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    idle_after("and", 8'h30, 1'b0);

    // Reset during RUN bit 3 of ADD FF+01.
    done_before = done_cnt;
    start_i = 1'b1; op_i = 2'b00; opa_i = 8'hFF; opb_i = 8'h01;
    @(posedge clk); #1; start_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("mid bit3 a", a_o, 1'b1);
    rst = 1'b1; #1;
    check("mid rst state", state_o, 2'd0);
    check("mid rst busy", busy_o, 1'b0);
    check("mid rst a", a_o, 1'b0);
    check("mid rst result", result_o, 8'h00);
    check("mid rst carry", carry_o, 1'b0);
    check("mid rst aluctr", aluctr_o, 2'b00);
    @(negedge clk); rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("mid rst no_done", done_cnt, done_before);

    run_op("add7f", 2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    idle_after("add7f", 8'h80, 1'b0);
    run_op("addff", 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    idle_after("addff", 8'h00, 1'b1);
    run_op("cmp53", 2'b10, 8'h05, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0);
    idle_after("cmp53", 8'h00, 1'b1);
    run_op("cmp35", 2'b10, 8'h03, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op("cmpeq", 2'b10, 8'h42, 8'h42, 8'h00, 1'b0, 1'b0, 1'b0);
    idle_after("cmpeq", 8'h00, 1'b0);

    // XOR then ADD accepted back-to-back in the DONE cycle.
    done_before = done_cnt;
    run_op("xor", 2'b11, 8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1'b0);
    run_op("b2b add", 2'b00, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);
    idle_after("b2b add", 8'h30, 1'b0);
    check("b2b pulses", done_cnt - done_before, 2);

    // start_i held high through RUN: exactly one result.
    done_before = done_cnt;
    run_op("hold", 2'b00, 8'h35, 8'h0C, 8'h41, 1'b0, 1'b0, 1'b1);
    idle_after("hold", 8'h41, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold pulses", done_cnt - done_before, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
